// File: rtl/uart_tx_frame_engine.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_frame_engine
//  Description : Parametrised UART transmitter with an internal baud divider,
//                configurable data width, parity and stop bits. Words arrive
//                over a valid/ready handshake into a one-deep holding register,
//                so consecutive frames can run with no idle gap.
//  Ports       : clk        - system clock, rising edge
//                rst        - asynchronous active-high reset
//                tx_data    - word to send, sampled on accept
//                tx_valid   - tx_data is valid
//                tx_ready   - holding register empty (accept = valid & ready)
//                tx_pin_out - serial line, idles high
//                busy       - frame in progress
//                frame_done - one-cycle pulse in the last cycle of the frame
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_frame_engine #(
    parameter int CLK_DIV   = 434,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_pin_out,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int c_cnt_w = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int c_bit_w = $clog2(DATA_BITS + 1);

    localparam logic [c_cnt_w-1:0] c_baud_last    = c_cnt_w'(CLK_DIV - 1);
    localparam logic [c_cnt_w-1:0] c_baud_prelast = c_cnt_w'(CLK_DIV - 2);
    localparam logic [c_bit_w-1:0] c_data_last    = c_bit_w'(DATA_BITS - 1);
    localparam logic [c_bit_w-1:0] c_stop_last    = c_bit_w'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_PAR   = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    initial begin
        if (CLK_DIV < 2)
            $error("uart_tx_frame_engine: CLK_DIV must be >= 2");
        if (DATA_BITS < 5 || DATA_BITS > 9)
            $error("uart_tx_frame_engine: DATA_BITS must be 5..9");
        if (PARITY < 0 || PARITY > 2)
            $error("uart_tx_frame_engine: PARITY must be 0, 1 or 2");
        if (STOP_BITS < 1 || STOP_BITS > 2)
            $error("uart_tx_frame_engine: STOP_BITS must be 1 or 2");
    end

    state_t                 r_state;
    logic [c_cnt_w-1:0]     r_baud;
    logic [c_bit_w-1:0]     r_bit_cnt;
    logic [DATA_BITS-1:0]   r_shift;
    logic [DATA_BITS-1:0]   r_word;
    logic [DATA_BITS-1:0]   r_hold;
    logic                   r_hold_full;

    logic w_accept;
    logic w_bit_end;
    logic w_frame_end;
    logic w_bypass;
    logic w_par_bit;

    assign w_accept    = tx_valid & tx_ready;
    assign w_bit_end   = (r_baud == c_baud_last);
    assign w_frame_end = (r_state == S_STOP) && w_bit_end && (r_bit_cnt == c_stop_last);
    // A word accepted on the very edge that closes a frame (hold empty) goes
    // straight into the shifter so the next start bit follows with no gap.
    assign w_bypass    = w_frame_end && !r_hold_full && w_accept;
    // Parity is taken from the latched copy of the word, not the shifter.
    assign w_par_bit   = (PARITY == 1) ? ~^r_word : ^r_word;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_baud      <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_word      <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            tx_ready    <= 1'b1;
            tx_pin_out  <= 1'b1;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            // Registered pulse: asserted for the cycle in which the counter
            // sits on its terminal value of the final stop bit.
            frame_done <= (r_state == S_STOP) && (r_bit_cnt == c_stop_last)
                          && (r_baud == c_baud_prelast);

            if (w_accept && !w_bypass) begin
                r_hold      <= tx_data;
                r_hold_full <= 1'b1;
                tx_ready    <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    r_baud <= '0;
                    if (r_hold_full) begin
                        r_shift     <= r_hold;
                        r_word      <= r_hold;
                        r_hold_full <= 1'b0;
                        tx_ready    <= 1'b1;
                        r_state     <= S_START;
                        tx_pin_out  <= 1'b0;
                        busy        <= 1'b1;
                    end
                end

                S_START: begin
                    if (w_bit_end) begin
                        r_baud     <= '0;
                        r_bit_cnt  <= '0;
                        r_state    <= S_DATA;
                        tx_pin_out <= r_shift[0];
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end

                S_DATA: begin
                    if (w_bit_end) begin
                        r_baud  <= '0;
                        r_shift <= {1'b0, r_shift[DATA_BITS-1:1]};
                        if (r_bit_cnt == c_data_last) begin
                            r_bit_cnt <= '0;
                            if (PARITY != 0) begin
                                r_state    <= S_PAR;
                                tx_pin_out <= w_par_bit;
                            end else begin
                                r_state    <= S_STOP;
                                tx_pin_out <= 1'b1;
                            end
                        end else begin
                            r_bit_cnt  <= r_bit_cnt + 1'b1;
                            tx_pin_out <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end

                S_PAR: begin
                    if (w_bit_end) begin
                        r_baud     <= '0;
                        r_bit_cnt  <= '0;
                        r_state    <= S_STOP;
                        tx_pin_out <= 1'b1;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end

                S_STOP: begin
                    if (w_bit_end) begin
                        r_baud <= '0;
                        if (r_bit_cnt == c_stop_last) begin
                            r_bit_cnt <= '0;
                            if (r_hold_full) begin
                                r_shift     <= r_hold;
                                r_word      <= r_hold;
                                r_hold_full <= 1'b0;
                                tx_ready    <= 1'b1;
                                r_state     <= S_START;
                                tx_pin_out  <= 1'b0;
                            end else if (w_accept) begin
                                r_shift    <= tx_data;
                                r_word     <= tx_data;
                                r_state    <= S_START;
                                tx_pin_out <= 1'b0;
                            end else begin
                                r_state    <= S_IDLE;
                                tx_pin_out <= 1'b1;
                                busy       <= 1'b0;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end

                default: begin
                    r_state    <= S_IDLE;
                    r_baud     <= '0;
                    r_bit_cnt  <= '0;
                    tx_pin_out <= 1'b1;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
